layer2: RTL
===========

LAYER2 -- requirements
Module: layer2

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-003 goL2  input  1  request from upstream generator; held high until doneL2 seen.
REQ-004 Din  input  8  candidate password; valid for exactly one cycle, the cycle before goL2 rises.
REQ-005 load_target  input  1  one-cycle strobe; loads target_in as the target hash.
REQ-006 target_in  input  16  target hash value.
REQ-007 doneL2  output  1  check complete; high while in DONE.
REQ-008 match  output  1  hash of last candidate equals target; valid while doneL2=1, else 0.
REQ-009 found  output  1  sticky: at least one match since reset/target load.
REQ-010 found_pw  output  8  first matching candidate; 0 until found.
REQ-011 attempts  output  16  completed checks since reset/target load, saturating at 16'hFFFF.
REQ-012 busy  output  1  high in HASH and CMP.

Function
REQ-013 FSM states SHALL be IDLE, HASH, CMP, DONE; doneL2, match, busy are Moore outputs of registered state.
REQ-014 In IDLE with goL2=0, shadow register SHALL load Din every cycle; it SHALL hold in all other cases.
REQ-015 IDLE -> HASH when goL2 sampled 1; h loads HASH_INIT=16'hA5C3; round counter r=0.
REQ-016 HASH: each cycle h <= (rotl(h,3) XOR {pw, ~pw}) + K[r] mod 2^16; pw = shadow; K = {16'h1F3D, 16'h2B71, 16'h3C95, 16'h4E07}; r increments.
REQ-017 HASH -> CMP after round r=3 (exactly 4 cycles in HASH).
REQ-018 CMP: match register <= (h == target); attempts increments (saturating); if match and found=0, found<=1, found_pw<=pw; CMP -> DONE unconditionally.
REQ-019 doneL2 SHALL first be high 5 rising edges after the edge at which goL2 was sampled high in IDLE.
REQ-020 DONE -> IDLE when goL2 sampled 0; otherwise stay in DONE with doneL2=1 (four-phase handshake).
REQ-021 goL2 dropping during HASH/CMP SHALL NOT abort; DONE then lasts one cycle.
REQ-022 goL2 high on the IDLE cycle entered from DONE SHALL start a new check (back-to-back).
REQ-023 load_target honoured only in IDLE: target<=target_in, found<=0, found_pw<=0, attempts<=0; ignored in other states.
REQ-024 found_pw SHALL NOT change on subsequent matches while found=1.
REQ-025 match SHALL be 0 outside DONE.

Reset
REQ-026 reset SHALL force IDLE, h=0, r=0, shadow=0, target=0, match=0, found=0, found_pw=0, attempts=0; doneL2=0, busy=0 next cycle.
REQ-027 reset mid-HASH/CMP/DONE SHALL discard the check; no attempts increment, no doneL2 pulse.
REQ-028 reset takes priority over load_target and goL2 in the same cycle.

Structure
REQ-029 Shared package layer_pkg SHALL hold the state enum, ROUNDS=4, HASH_INIT, round-constant array K.
REQ-030 Round function SHALL be a combinational sub-module hash_round (inputs h, pw, k; output h_next), instantiated once.
REQ-031 No combinational path from goL2 or Din to any output.

Verification
REQ-032 Reset, load_target 0x0000 ignored-check; Din=0x00, goL2 -> doneL2 at edge 5, attempts=1, busy high 5 cycles.
REQ-033 Load target=model_hash(0x2A); candidates 0x28,0x29,0x2A,0x2B -> match=1 only for 0x2A, found=1, found_pw=0x2A, attempts=4.
REQ-034 Two matching candidates (target=model_hash(0x05), 0x05 sent twice) -> found_pw stays 0x05, match high both DONE phases.
REQ-035 goL2 held high 3 cycles after doneL2 -> doneL2 stays high until goL2=0, then IDLE; goL2 dropped in HASH -> DONE lasts 1 cycle.
REQ-036 reset asserted at HASH round 2 -> no doneL2, attempts unchanged; load_target during HASH -> target unchanged.
REQ-037 Force attempts to 16'hFFFE, run 3 checks -> attempts saturates at 16'hFFFF.

Source files
------------

// File: rtl/layer_pkg.sv
// Shared types and constants for the layer-2 password hash checker.
package layer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HASH,
        S_CMP,
        S_DONE
    } state_e;

    localparam int ROUNDS = 4;
    localparam logic [15:0] HASH_INIT = 16'hA5C3;

    // Index 0 is the rightmost element.
    localparam logic [ROUNDS-1:0][15:0] K = {
        16'h4E07, 16'h3C95, 16'h2B71, 16'h1F3D
    };

endpackage

// File: rtl/layer2_hash_round.sv
// One combinational round of the 16-bit password hash.
module hash_round
    import layer_pkg::*;
(
    input  logic [15:0] h_i,
    input  logic [7:0]  pw_i,
    input  logic [15:0] k_i,
    output logic [15:0] h_next_o
);

    logic [15:0] rot;

    assign rot      = {h_i[12:0], h_i[15:13]};
    assign h_next_o = (rot ^ {pw_i, ~pw_i}) + k_i;

endmodule

// File: rtl/layer2.sv
// Layer-2 checker: hashes a candidate in 4 rounds and compares it to a target.
module layer2
    import layer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        goL2,
    input  logic [7:0]  Din,
    input  logic        load_target,
    input  logic [15:0] target_in,
    output logic        doneL2,
    output logic        match,
    output logic        found,
    output logic [7:0]  found_pw,
    output logic [15:0] attempts,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [15:0] h_q, h_d;
    logic [1:0]  r_q, r_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [15:0] target_q, target_d;
    logic        match_q, match_d;
    logic        found_q, found_d;
    logic [7:0]  fpw_q, fpw_d;
    logic [15:0] attempts_q, attempts_d;
    logic [15:0] h_rnd;
    logic        hit;

    hash_round u_round (
        .h_i      (h_q),
        .pw_i     (shadow_q),
        .k_i      (K[r_q]),
        .h_next_o (h_rnd)
    );

    assign hit = (h_q == target_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            h_q        <= '0;
            r_q        <= '0;
            shadow_q   <= '0;
            target_q   <= '0;
            match_q    <= 1'b0;
            found_q    <= 1'b0;
            fpw_q      <= '0;
            attempts_q <= '0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            r_q        <= r_d;
            shadow_q   <= shadow_d;
            target_q   <= target_d;
            match_q    <= match_d;
            found_q    <= found_d;
            fpw_q      <= fpw_d;
            attempts_q <= attempts_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        r_d        = r_q;
        shadow_d   = shadow_q;
        target_d   = target_q;
        match_d    = match_q;
        found_d    = found_q;
        fpw_d      = fpw_q;
        attempts_d = attempts_q;
        unique case (state_q)
            S_IDLE: begin
                match_d = 1'b0;
                if (load_target) begin
                    target_d   = target_in;
                    found_d    = 1'b0;
                    fpw_d      = '0;
                    attempts_d = '0;
                end
                if (goL2) begin
                    state_d = S_HASH;
                    h_d     = HASH_INIT;
                    r_d     = '0;
                end else begin
                    shadow_d = Din;
                end
            end
            S_HASH: begin
                h_d = h_rnd;
                r_d = r_q + 2'd1;
                if (r_q == 2'(ROUNDS - 1)) state_d = S_CMP;
            end
            S_CMP: begin
                match_d = hit;
                if (attempts_q != 16'hFFFF) attempts_d = attempts_q + 16'd1;
                // Only the first matching candidate is remembered.
                if (hit && !found_q) begin
                    found_d = 1'b1;
                    fpw_d   = shadow_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!goL2) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign doneL2   = (state_q == S_DONE);
    assign busy     = (state_q == S_HASH) || (state_q == S_CMP);
    assign match    = match_q && doneL2;
    assign found    = found_q;
    assign found_pw = fpw_q;
    assign attempts = attempts_q;

endmodule
